// File: rtl/keypad_pkg.sv
// keypad_pkg: ASCII key codes and controller state encoding shared by keypad logic
package keypad_pkg;
  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_9    = 8'h39;
  localparam logic [7:0] ASC_STAR = 8'h2A;
  localparam logic [7:0] ASC_HASH = 8'h23;
  localparam logic [7:0] ASC_A    = 8'h41;
  localparam logic [7:0] ASC_B    = 8'h42;
  localparam logic [7:0] ASC_C    = 8'h43;
  localparam logic [7:0] ASC_D    = 8'h44;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_POP = 2'd1, ST_DECODE = 2'd2, ST_HOLD = 2'd3} state_e;
endpackage

// File: rtl/keypad_char_decode.sv
// keypad_char_decode: classifies one ASCII keypad character into editing actions
module keypad_char_decode
  import keypad_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_back,
  output logic       is_clear,
  output logic       is_enter
);
  assign is_digit = (ch >= ASC_0) && (ch <= ASC_9);
  assign digit    = ch[3:0];
  assign is_back  = ch == ASC_STAR;
  assign is_clear = ch == ASC_A;
  assign is_enter = ch == ASC_HASH;
endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: pops keypad characters from a FIFO and edits a BCD entry
// until '#' commits it; the committed entry is held until the consumer accepts.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input  logic                            CLK_50,
  input  logic                            RESET_IN,
  input  logic                            fifo_empty,
  input  logic [7:0]                      fifo_data,
  output logic                            fifo_rd,
  input  logic                            entry_ready,
  output logic                            entry_valid,
  output logic [4*MAX_DIGITS-1:0]         entry_bcd,
  output logic [$clog2(MAX_DIGITS+1)-1:0] entry_len,
  output logic                            overflow,
  output logic [1:0]                      state_out
);
  localparam int BW = 4 * MAX_DIGITS;
  localparam int LW = $clog2(MAX_DIGITS + 1);
  state_e        state_q, state_d;
  logic          fifo_rd_q, fifo_rd_d;
  logic          valid_q, valid_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic [LW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          is_digit, is_back, is_clear, is_enter;
  logic [3:0]    digit;

  keypad_char_decode u_dec (
    .ch       (fifo_data),
    .is_digit (is_digit),
    .digit    (digit),
    .is_back  (is_back),
    .is_clear (is_clear),
    .is_enter (is_enter)
  );

  always_comb begin
    state_d   = state_q;
    fifo_rd_d = 1'b0;
    valid_d   = valid_q;
    bcd_d     = bcd_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: begin
        state_d   = fifo_empty ? ST_IDLE : ST_POP;
        fifo_rd_d = !fifo_empty;
      end
      ST_POP: state_d = ST_DECODE;
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (is_digit) begin
          if (len_q < LW'(MAX_DIGITS)) begin
            bcd_d = (bcd_q << 4) | BW'(digit);
            len_d = len_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (is_back && len_q != '0) begin
          bcd_d = bcd_q >> 4;
          len_d = len_q - 1'b1;
        end else if (is_clear) begin
          bcd_d = '0;
          len_d = '0;
          ovf_d = 1'b0;
        end else if (is_enter && len_q != '0) begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (entry_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          bcd_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset overrides DECODE, so a character caught mid-pop is simply dropped
  always_ff @(posedge CLK_50) begin
    if (!RESET_IN) begin
      state_q   <= ST_IDLE;
      fifo_rd_q <= 1'b0;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fifo_rd_q <= fifo_rd_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
    end
  end

  assign fifo_rd     = fifo_rd_q;
  assign entry_valid = valid_q;
  assign entry_bcd   = bcd_q;
  assign entry_len   = len_q;
  assign overflow    = ovf_q;
  assign state_out   = state_q;
endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter MAX_DIGITS, default 4, maximum digits held in one entry (1..8).
REQ-002 CLK_50  input  1  single system clock; all logic on rising edge.
REQ-003 RESET_IN  input  1  reset, synchronous and active-low.
REQ-004 fifo_empty  input  1  scanner FIFO empty flag.
REQ-005 fifo_data  input  8  scanner FIFO read data (ASCII), valid the cycle after fifo_rd.
REQ-006 fifo_rd  output  1  registered one-cycle pop strobe to scanner FIFO.
REQ-007 entry_ready  input  1  consumer accepts committed entry.
REQ-008 entry_valid  output  1  committed entry available; held until accepted.
REQ-009 entry_bcd  output  4*MAX_DIGITS  BCD digits, newest in bits [3:0]; live while editing, frozen while entry_valid.
REQ-010 entry_len  output  $clog2(MAX_DIGITS+1)  number of digits currently held.
REQ-011 overflow  output  1  sticky: a digit was dropped because the entry was full.
REQ-012 state_out  output  2  current state encoding, for debug/LED display.

Function
REQ-013 States SHALL be IDLE, POP, DECODE, HOLD.
REQ-014 IDLE -> POP when fifo_empty=0; otherwise remain in IDLE.
REQ-015 POP: fifo_rd=1 for exactly this cycle; POP -> DECODE unconditionally.
REQ-016 DECODE: sample fifo_data, apply REQ-017..REQ-022, then -> HOLD on commit, else -> IDLE.
REQ-017 '0'..'9' (0x30..0x39): if entry_len<MAX_DIGITS, shift entry_bcd left 4 bits, insert digit in [3:0], entry_len+1.
REQ-018 Digit with entry_len=MAX_DIGITS: digit discarded, entry_bcd/entry_len unchanged, overflow set.
REQ-019 '*' (0x2A) backspace: if entry_len>0, shift entry_bcd right 4 bits (zero fill), entry_len-1; if entry_len=0, no-op.
REQ-020 'A' (0x41) clear: entry_bcd=0, entry_len=0, overflow=0.
REQ-021 '#' (0x23) enter: if entry_len>0, commit (entry_valid=1 from next cycle); if entry_len=0, ignored.
REQ-022 Any other code ('B','C','D', non-keypad values) SHALL be ignored with no state change.
REQ-023 HOLD: entry_valid=1, entry_bcd/entry_len frozen, fifo_rd=0; FIFO characters wait in FIFO.
REQ-024 HOLD with entry_ready=1 sampled: next cycle entry_valid=0, entry_bcd=0, entry_len=0, overflow=0, state IDLE.
REQ-025 entry_ready while not in HOLD SHALL have no effect.
REQ-026 Timing: fifo_empty falls in IDLE at cycle n -> fifo_rd high cycle n+1 -> buffer updated cycle n+3; max throughput one character per 3 cycles.
REQ-027 fifo_rd SHALL never be asserted while fifo_empty=1 in the preceding IDLE cycle, nor on two consecutive cycles.

Reset
REQ-028 RESET_IN=0 at a clock edge: state IDLE, fifo_rd=0, entry_valid=0, entry_bcd=0, entry_len=0, overflow=0, state_out=IDLE.
REQ-029 Reset asserted in any state (including POP/DECODE mid-pop) SHALL abandon the character in progress with no partial update.

Structure
REQ-030 Shared package keypad_pkg SHALL hold the ASCII constants (digits, '*', '#', 'A'..'D') and the state encoding, shared with matrix scanner code.
REQ-031 One sub-module keypad_char_decode: combinational classifier ASCII -> {is_digit, digit[3:0], is_back, is_clear, is_enter}.
REQ-032 RTL SHALL have no latches and no derived clocks; all state in CLK_50 domain.

Verification
REQ-033 Push '1','2','3','#' into FIFO model -> entry_valid=1, entry_bcd[11:0]=0x123, entry_len=3; hold until entry_ready pulse, then all cleared.
REQ-034 MAX_DIGITS=4, push '9','8','7','6','5' -> entry_bcd=0x9876, entry_len=4, overflow=1; then 'A' -> entry_bcd=0, entry_len=0, overflow=0.
REQ-035 Push '*' on empty entry, then '4','*','#' -> no change, then entry_len=0 and '#' ignored, entry_valid stays 0.
REQ-036 In HOLD with three characters queued, keep entry_ready=0 for 20 cycles -> fifo_rd stays 0; raise entry_ready -> pops resume 2 cycles later.
REQ-037 Assert RESET_IN=0 in the DECODE cycle of '7' with entry 0x12 -> next cycle all outputs at reset values, '7' not applied.
REQ-038 Push 'B','C','D',0xFF -> each popped (four fifo_rd pulses, 3 cycles apart), entry_bcd and entry_len unchanged.
